vga_linear_fetch: RTL and testbench
===================================

Name: vga_linear_fetch

Overview:
- Pixel fetch and serialiser for the 320x200, 256-colour linear graphics mode (mode 13h style).
- Driven by the CRTC's 640x400 h_count/v_count timing; each source pixel is doubled horizontally and vertically.
- Reads one 16-bit word (two pixels) from video memory over a CSR read bus every 4 clocks.
- Outputs an 8-bit palette index with sync and blank delayed to match; sits beside vga_planar/vga_text_mode ahead of the DAC/palette mux.

Parameters:
- DATA_LAT, 2: clocks from the cycle csr_stb_o is high to the cycle csr_dat_i is valid (fixed, no ack). Legal range 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- csr_adr_o  out  17  word address, bits [17:1]
- csr_dat_i  in  16  read data; low byte = even pixel
- csr_stb_o  out  1  read strobe, one-cycle pulse
- h_count  in  10  horizontal pixel counter (0..799)
- v_count  in  10  vertical line counter
- horiz_sync_i  in  1  horizontal sync from CRTC
- video_on_h_i  in  1  horizontal display enable
- video_on_h_o  out  1  display enable, delayed by L
- horiz_sync_o  out  1  horizontal sync, delayed by L
- color  out  8  palette index, delayed by L

Behaviour:
- Latency L = DATA_LAT+3 clocks from the (h_count, horiz_sync_i, video_on_h_i) inputs to (color, horiz_sync_o, video_on_h_o). All three outputs are aligned.
- Address:
  - x = h_count[9:1], y = v_count[8:1].
  - Word index = y*160 + h_count[9:2], computed in 17 bits, zero-extended, no wrap below 2^17.
  - Reference values: y=0,h=0 -> 0; y=1 -> 160; y=199 -> 31840.
- Strobe:
  - When h_count[1:0]==0 and video_on_h_i==1, csr_adr_o and csr_stb_o=1 are registered at the next edge.
  - csr_stb_o is high for exactly one cycle per 4-clock group and low otherwise.
  - csr_adr_o holds its last value while strobe is low.
- Data capture:
  - csr_dat_i is sampled into a word register at the end of the cycle DATA_LAT clocks after the strobe-high cycle, only for cycles that had a strobe.
  - The word register otherwise holds its value.
- Pixel select, registered one clock after capture, using the pipelined h_count[1:0]:
  - h_count[1]==0 -> word[7:0]; h_count[1]==1 -> word[15:8].
  - Each byte is therefore shown for 2 consecutive clocks.
- Blanking: color = 0 whenever the delayed video_on_h is 0. No fetch occurs during blank.
- video_on_h_o and horiz_sync_o are pure L-stage shift registers of the inputs.
- v_count beyond 399 is not gated; the address keeps computing (the CRTC blanks vertically downstream).
- Reset:
  - Values: csr_stb_o=0, csr_adr_o=0, word register=0, color=0, video_on_h_o=0 (whole pipe 0), horiz_sync_o=1 (whole pipe 1).
  - Reset mid-line: all pending fetches are discarded; the first output after reset release comes L clocks after valid inputs.
- No internal state machine beyond the fixed pipeline. No backpressure; the slave must meet DATA_LAT.

Optional Feature:
- VGA_LINEAR_START_ADDR_EN
- When defined:
  - Adds input port start_addr, 17 bits: a word offset (CRTC start address) added to the word index modulo 2^17 before registering csr_adr_o.
  - start_addr is sampled with h_count, so a change takes effect on the next strobe.
- When undefined: no port; the offset is 0.

Test Plan:
- Reset held 1 clock then released, inputs idle -> csr_stb_o=0, color=0, video_on_h_o=0, horiz_sync_o=1 until L clocks after active inputs.
- Free-running 800x449 timing, v_count=0, h_count 0..15 with video_on -> strobes 1 clock after h=0,4,8,12 with csr_adr_o=0,1,2,3; exactly one strobe per 4 clocks, none for h>=640.
- v_count=2 (y=1), h_count=0 -> csr_adr_o=160; v_count=398, h_count=636 -> csr_adr_o=31840+159=31999.
- Slave returns 16'hBEEF DATA_LAT clocks after each strobe -> color sequence EF,EF,BE,BE repeating, starting L=5 clocks after h_count=0.
- video_on_h_i deasserts at h=640 -> video_on_h_o falls and color forced to 0 exactly L clocks later; horiz_sync_o mirrors horiz_sync_i delayed by L.
- With VGA_LINEAR_START_ADDR_EN, start_addr=17'h1FFFF, y=0, h=4 -> csr_adr_o=0 (modulo wrap).

Source files
------------

// File: rtl/vga_linear_fetch.sv
// Linear 320x200x256 pixel fetch/serialiser: one 16-bit word per 4 clocks, pixels doubled in x and y.
// Optional macro VGA_LINEAR_START_ADDR_EN adds a start_addr word offset to every fetch address.
module vga_linear_fetch #(
  parameter int DATA_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [16:0] csr_adr_o,
  input  logic [15:0] csr_dat_i,
  output logic        csr_stb_o,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        horiz_sync_i,
  input  logic        video_on_h_i,
`ifdef VGA_LINEAR_START_ADDR_EN
  input  logic [16:0] start_addr,
`endif
  output logic        video_on_h_o,
  output logic        horiz_sync_o,
  output logic [7:0]  color
);

  localparam int LAT = DATA_LAT + 3;

  logic [7:0]  row;
  logic [16:0] row_base;
  logic [16:0] word_index;
  logic [16:0] addr_next;
  logic        fetch_req;
  logic        unused_bits;

  // y*160 as y*128 + y*32; worst case 255*160+255 still fits in 17 bits.
  assign row        = v_count[8:1];
  assign row_base   = {2'b00, row, 7'b0000000} + {4'b0000, row, 5'b00000};
  assign word_index = row_base + {9'b0, h_count[9:2]};
`ifdef VGA_LINEAR_START_ADDR_EN
  assign addr_next  = word_index + start_addr;
`else
  assign addr_next  = word_index;
`endif
  assign fetch_req   = video_on_h_i && (h_count[1:0] == 2'b00);
  assign unused_bits = ^{v_count[9], v_count[0], h_count[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_stb_o <= 1'b0;
      csr_adr_o <= 17'd0;
    end else begin
      csr_stb_o <= fetch_req;
      if (fetch_req) begin
        csr_adr_o <= addr_next;
      end
    end
  end

  // Strobe delayed by DATA_LAT marks the cycle in which the slave's data is valid.
  logic [DATA_LAT-1:0] stb_dly_reg;
  logic [15:0]         word_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_LAT; gi++) begin : g_stb_dly
      always_ff @(posedge clk) begin
        if (rst) begin
          stb_dly_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          stb_dly_reg[gi] <= csr_stb_o;
        end else begin
          stb_dly_reg[gi] <= stb_dly_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg <= 16'd0;
    end else if (stb_dly_reg[DATA_LAT-1]) begin
      word_reg <= csr_dat_i;
    end
  end

  // Timing side-band: enable, sync and byte select ride alongside the fetch.
  logic [LAT-1:0] von_pipe_reg;
  logic [LAT-1:0] hs_pipe_reg;
  logic [LAT-2:0] sel_pipe_reg;

  generate
    for (gi = 0; gi < LAT; gi++) begin : g_timing_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          von_pipe_reg[gi] <= 1'b0;
          hs_pipe_reg[gi]  <= 1'b1;
        end else if (gi == 0) begin
          von_pipe_reg[gi] <= video_on_h_i;
          hs_pipe_reg[gi]  <= horiz_sync_i;
        end else begin
          von_pipe_reg[gi] <= von_pipe_reg[(gi == 0) ? 0 : gi - 1];
          hs_pipe_reg[gi]  <= hs_pipe_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end

    for (gi = 0; gi < LAT - 1; gi++) begin : g_sel_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          sel_pipe_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          sel_pipe_reg[gi] <= h_count[1];
        end else begin
          sel_pipe_reg[gi] <= sel_pipe_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  logic [7:0] color_next;

  always_comb begin
    color_next = 8'd0;
    if (von_pipe_reg[LAT-2]) begin
      color_next = sel_pipe_reg[LAT-2] ? word_reg[15:8] : word_reg[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      color <= 8'd0;
    end else begin
      color <= color_next;
    end
  end

  assign video_on_h_o = von_pipe_reg[LAT-1];
  assign horiz_sync_o = hs_pipe_reg[LAT-1];

endmodule

// File: tb/tb_vga_linear_fetch.sv
// Directed bench for vga_linear_fetch with a fixed-latency read slave model.
module tb_vga_linear_fetch;

  localparam int DATA_LAT = 2;
  localparam int LAT      = DATA_LAT + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] csr_adr_o;
  logic [15:0] csr_dat_i;
  logic        csr_stb_o;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        horiz_sync_i;
  logic        video_on_h_i;
  logic        video_on_h_o;
  logic        horiz_sync_o;
  logic [7:0]  color;
`ifdef VGA_LINEAR_START_ADDR_EN
  logic [16:0] start_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int data_mode = 0;

  logic        sl_stb [0:DATA_LAT-1];
  logic [16:0] sl_adr [0:DATA_LAT-1];

  logic [9:0] sh   [0:1023];
  logic       svon [0:1023];
  logic       shs  [0:1023];

  vga_linear_fetch #(.DATA_LAT(DATA_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_adr_o    (csr_adr_o),
    .csr_dat_i    (csr_dat_i),
    .csr_stb_o    (csr_stb_o),
    .h_count      (h_count),
    .v_count      (v_count),
    .horiz_sync_i (horiz_sync_i),
    .video_on_h_i (video_on_h_i),
`ifdef VGA_LINEAR_START_ADDR_EN
    .start_addr   (start_addr),
`endif
    .video_on_h_o (video_on_h_o),
    .horiz_sync_o (horiz_sync_o),
    .color        (color)
  );

  always #5 clk = ~clk;

  // Slave: data valid exactly DATA_LAT clocks after the strobe cycle, zero otherwise.
  initial begin
    for (int k = 0; k < DATA_LAT; k++) begin
      sl_stb[k] = 1'b0;
      sl_adr[k] = 17'd0;
    end
  end

  always @(posedge clk) begin
    sl_stb[0] <= csr_stb_o;
    sl_adr[0] <= csr_adr_o;
    for (int k = 1; k < DATA_LAT; k++) begin
      sl_stb[k] <= sl_stb[k-1];
      sl_adr[k] <= sl_adr[k-1];
    end
  end

  assign csr_dat_i = sl_stb[DATA_LAT-1] ?
                     ((data_mode == 0) ? 16'hBEEF : {~sl_adr[DATA_LAT-1][7:0], sl_adr[DATA_LAT-1][7:0]}) :
                     16'h0000;

  task automatic drive_idle();
    h_count      = 10'd0;
    video_on_h_i = 1'b0;
    horiz_sync_i = 1'b1;
  endtask

  task automatic flush();
    drive_idle();
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v_count = 10'd0;
    drive_idle();
`ifdef VGA_LINEAR_START_ADDR_EN
    start_addr = 17'd0;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (csr_stb_o !== 1'b0 || csr_adr_o !== 17'd0 || color !== 8'd0 ||
        video_on_h_o !== 1'b0 || horiz_sync_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: stb=%b adr=%0d color=%h von=%b hs=%b required 0 0 00 0 1",
               csr_stb_o, csr_adr_o, color, video_on_h_o, horiz_sync_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Sync low straight after release: the output must stay 1 until LAT clocks later.
    for (int c = 0; c < LAT + 3; c++) begin
      h_count      = 10'd700;
      video_on_h_i = 1'b0;
      horiz_sync_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (horiz_sync_o !== ((c < LAT) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL reset_hsync c=%0d: got %b required %b", c, horiz_sync_o, (c < LAT) ? 1'b1 : 1'b0);
      end
      n_checks++;
      if (csr_stb_o !== 1'b0 || color !== 8'd0 || video_on_h_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: stb=%b color=%h von=%b required 0 00 0", c, csr_stb_o, color, video_on_h_o);
      end
      @(posedge clk); #1;
    end
    flush();
    $display("test_reset done, failures so far %0d", n_fail);
  endtask

  task automatic test_free_run(input int v, input int mode);
    int         exp_a;
    logic [16:0] a17;
    logic       exp_stb;
    logic [7:0] exp_c;
    int         i;
    data_mode = mode;
    v_count   = v[9:0];
    for (int c = 0; c < 800 + LAT; c++) begin
      if (c < 800) begin
        h_count      = c[9:0];
        video_on_h_i = (c < 640);
        horiz_sync_i = !(c >= 656 && c < 752);
      end else begin
        drive_idle();
      end
      sh[c] = h_count; svon[c] = video_on_h_i; shs[c] = horiz_sync_i;
      @(negedge clk);
      if (c >= 1 && c <= 800) begin
        exp_stb = svon[c-1] && (sh[c-1][1:0] == 2'b00);
        n_checks++;
        if (csr_stb_o !== exp_stb) begin
          n_fail++;
          $display("FAIL stb v=%0d h=%0d: got %b required %b", v, sh[c-1], csr_stb_o, exp_stb);
        end
        if (exp_stb) begin
          exp_a = (v / 2) * 160 + int'(sh[c-1]) / 4;
          n_checks++;
          if (csr_adr_o !== exp_a[16:0]) begin
            n_fail++;
            $display("FAIL adr v=%0d h=%0d: got %0d required %0d", v, sh[c-1], csr_adr_o, exp_a);
          end
        end
      end
      if (c >= LAT) begin
        i = c - LAT;
        exp_a = (v / 2) * 160 + int'(sh[i]) / 4;
        a17 = exp_a[16:0];
        if (!svon[i]) exp_c = 8'h00;
        else if (mode == 0) exp_c = sh[i][1] ? 8'hBE : 8'hEF;
        else exp_c = sh[i][1] ? ~a17[7:0] : a17[7:0];
        n_checks++;
        if (color !== exp_c || video_on_h_o !== svon[i] || horiz_sync_o !== shs[i]) begin
          n_fail++;
          $display("FAIL pixel v=%0d h=%0d: color=%h von=%b hs=%b required %h %b %b",
                   v, sh[i], color, video_on_h_o, horiz_sync_o, exp_c, svon[i], shs[i]);
        end
      end
      @(posedge clk); #1;
    end
    flush();
    $display("test_free_run v=%0d mode=%0d done, failures so far %0d", v, mode, n_fail);
  endtask

  task automatic test_address();
    data_mode = 0;
    h_count = 10'd0; v_count = 10'd2; video_on_h_i = 1'b1; horiz_sync_i = 1'b1;
    @(posedge clk); #1;
    drive_idle(); h_count = 10'd1;
    @(negedge clk);
    n_checks++;
    if (csr_stb_o !== 1'b1 || csr_adr_o !== 17'd160) begin
      n_fail++;
      $display("FAIL adr_y1: stb=%b adr=%0d required 1 160", csr_stb_o, csr_adr_o);
    end
    @(posedge clk); #1;
    h_count = 10'd636; v_count = 10'd398; video_on_h_i = 1'b1;
    @(posedge clk); #1;
    drive_idle(); h_count = 10'd637;
    @(negedge clk);
    n_checks++;
    if (csr_stb_o !== 1'b1 || csr_adr_o !== 17'd31999) begin
      n_fail++;
      $display("FAIL adr_last: stb=%b adr=%0d required 1 31999", csr_stb_o, csr_adr_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (csr_stb_o !== 1'b0 || csr_adr_o !== 17'd31999) begin
      n_fail++;
      $display("FAIL adr_hold: stb=%b adr=%0d required 0 31999", csr_stb_o, csr_adr_o);
    end
    @(posedge clk); #1;
    v_count = 10'd0;
    flush();
    $display("test_address done, failures so far %0d", n_fail);
  endtask

  task automatic test_reset_midline();
    logic       exp_stb;
    logic [7:0] exp_c;
    int         i;
    data_mode = 0;
    v_count = 10'd0;
    for (int c = 0; c < 40; c++) begin
      rst = (c == 19);
      h_count = c[9:0]; video_on_h_i = 1'b1; horiz_sync_i = 1'b1;
      sh[c] = h_count; svon[c] = 1'b1; shs[c] = 1'b1;
      @(negedge clk);
      if (c >= 1) begin
        exp_stb = (c == 20) ? 1'b0 : (sh[c-1][1:0] == 2'b00);
        n_checks++;
        if (csr_stb_o !== exp_stb) begin
          n_fail++;
          $display("FAIL midrst_stb c=%0d: got %b required %b", c, csr_stb_o, exp_stb);
        end
        if (exp_stb) begin
          n_checks++;
          if (csr_adr_o !== {9'd0, sh[c-1][9:2]}) begin
            n_fail++;
            $display("FAIL midrst_adr c=%0d: got %0d required %0d", c, csr_adr_o, sh[c-1][9:2]);
          end
        end
      end
      if (c >= 20 && c < 20 + LAT) begin
        n_checks++;
        if (color !== 8'd0 || video_on_h_o !== 1'b0 || horiz_sync_o !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_flush c=%0d: color=%h von=%b hs=%b required 00 0 1",
                   c, color, video_on_h_o, horiz_sync_o);
        end
      end else if (c >= LAT) begin
        i = c - LAT;
        exp_c = sh[i][1] ? 8'hBE : 8'hEF;
        n_checks++;
        if (color !== exp_c || video_on_h_o !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_pixel c=%0d: color=%h von=%b required %h 1", c, color, video_on_h_o, exp_c);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    flush();
    $display("test_reset_midline done, failures so far %0d", n_fail);
  endtask

`ifdef VGA_LINEAR_START_ADDR_EN
  task automatic test_start_addr();
    start_addr = 17'h1FFFF;
    v_count = 10'd0; h_count = 10'd4; video_on_h_i = 1'b1; horiz_sync_i = 1'b1;
    @(posedge clk); #1;
    h_count = 10'd8;
    @(negedge clk);
    n_checks++;
    if (csr_stb_o !== 1'b1 || csr_adr_o !== 17'd0) begin
      n_fail++;
      $display("FAIL start_wrap: stb=%b adr=%0d required 1 0", csr_stb_o, csr_adr_o);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (csr_stb_o !== 1'b1 || csr_adr_o !== 17'd1) begin
      n_fail++;
      $display("FAIL start_next: stb=%b adr=%0d required 1 1", csr_stb_o, csr_adr_o);
    end
    @(posedge clk); #1;
    start_addr = 17'd0;
    flush();
    $display("test_start_addr done, failures so far %0d", n_fail);
  endtask
`endif

  initial begin
    test_reset();
    test_free_run(0, 0);
    test_address();
    test_free_run(2, 1);
    test_reset_midline();
`ifdef VGA_LINEAR_START_ADDR_EN
    test_start_addr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
